// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit
// geometry and the preset sanitiser.
package timer_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned UNITS_MOD = 10;
    localparam int unsigned TENS_MOD  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Clamp an out-of-range BCD digit to the largest legal value for its modulus.
    function automatic logic [DIGIT_W-1:0] sanitise_digit(
        input logic [DIGIT_W-1:0] d,
        input int unsigned        modulus
    );
        logic [DIGIT_W-1:0] top;
        top = DIGIT_W'(modulus - 1);
        return (d > top) ? top : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; borrow requests a decrement of the next digit.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int unsigned MOD = UNITS_MOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dec_in,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MOD - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec_in) begin
            q <= (q == '0) ? TOP : q - DIGIT_W'(1);
        end
    end

    assign borrow = dec_in && (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer with prescaler, pause/resume, restart from a
// stored preset and a one-cycle done pulse on reaching zero.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned MIN_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          start,
    input  logic                          pause,
    input  logic                          ce,
    input  logic [4*MIN_DIGITS-1:0]       min_in,
    input  logic [7:0]                    sec_in,
    output logic [4*(MIN_DIGITS+2)-1:0]   digits,
    output logic                          running,
    output logic                          expired,
    output logic                          done
);

    localparam int unsigned NDIG = MIN_DIGITS + 2;
    localparam int unsigned CW   = DIGIT_W * NDIG;
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [CW-1:0] preset;
    logic [CW-1:0] count;
    logic [CW-1:0] raw_c;
    logic [CW-1:0] san_c;
    logic [CW-1:0] load_val_c;
    logic [NDIG-1:0] dec_c;
    logic [NDIG-1:0] borrow_c;

    logic count_zero_c;
    logic count_one_c;
    logic pause_go_c;
    logic start_go_c;
    logic reload_c;
    logic tick_c;
    logic reach_zero_c;
    logic digit_load_c;

    assign raw_c        = {min_in, sec_in};
    assign count_zero_c = (count == '0);
    assign count_one_c  = (count == CW'(1));

    // Request decode: load beats pause beats start; pause only acts in RUN.
    always_comb begin
        pause_go_c = 1'b0;
        start_go_c = 1'b0;
        if (!load) begin
            pause_go_c = pause && (state == ST_RUN);
            if (start && !pause_go_c) begin
                case (state)
                    ST_IDLE:    start_go_c = !count_zero_c;
                    ST_PAUSE:   start_go_c = 1'b1;
                    ST_EXPIRED: start_go_c = (preset != '0);
                    default:    start_go_c = 1'b0;
                endcase
            end
        end
    end

    assign reload_c     = start_go_c && (state == ST_EXPIRED);
    assign tick_c       = (state == ST_RUN) && ce && !load && !pause_go_c && (presc == PMAX);
    // A top-digit borrow would mean a zero count; expire instead of wrapping on.
    assign reach_zero_c = tick_c && (count_one_c || borrow_c[NDIG-1]);
    assign digit_load_c = load || reload_c;
    assign load_val_c   = load ? san_c : preset;
    assign dec_c        = {borrow_c[NDIG-2:0], tick_c};

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        localparam int unsigned M = (gi == 1) ? TENS_MOD : UNITS_MOD;

        assign san_c[gi*DIGIT_W +: DIGIT_W] = sanitise_digit(raw_c[gi*DIGIT_W +: DIGIT_W], M);

        bcd_down_digit #(
            .MOD (M)
        ) u_digit (
            .clk      (clk),
            .reset    (reset),
            .dec_in   (dec_c[gi]),
            .load     (digit_load_c),
            .load_val (load_val_c[gi*DIGIT_W +: DIGIT_W]),
            .q        (count[gi*DIGIT_W +: DIGIT_W]),
            .borrow   (borrow_c[gi])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = ST_IDLE;
        end else if (pause_go_c) begin
            state_nxt = ST_PAUSE;
        end else if (start_go_c) begin
            state_nxt = ST_RUN;
        end else if (reach_zero_c) begin
            state_nxt = ST_EXPIRED;
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        running = 1'b0;
        expired = 1'b0;
        case (state)
            ST_RUN:     running = 1'b1;
            ST_EXPIRED: expired = 1'b1;
            default: ;
        endcase
    end

    // Prescaler: cleared on load and fresh starts, kept across pause/resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (load || (start_go_c && state != ST_PAUSE)) begin
            presc <= '0;
        end else if (state == ST_RUN && ce && !pause_go_c) begin
            presc <= (presc == PMAX) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset <= '0;
            done   <= 1'b0;
        end else begin
            if (load) begin
                preset <= san_c;
            end
            done <= reach_zero_c;
        end
    end

    assign digits = count;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: a seconds-based reference model
// checked every cycle, plus literal spot checks.
module tb_bcd_countdown_timer;

    localparam int unsigned TD = 4;
    localparam int unsigned MD = 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_EXP  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        ce = 1'b1;
    logic [7:0]  min_in = 8'h00;
    logic [7:0]  sec_in = 8'h00;
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int m_mode  = M_IDLE;
    int m_sec   = 0;
    int m_pre   = 0;
    int m_presc = 0;
    bit m_done  = 1'b0;

    bcd_countdown_timer #(
        .TICK_DIV   (TD),
        .MIN_DIGITS (MD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .ce      (ce),
        .min_in  (min_in),
        .sec_in  (sec_in),
        .digits  (digits),
        .running (running),
        .expired (expired),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    // Preset as a number of seconds after clamping illegal digits.
    function automatic int preset_secs(input logic [7:0] mi, input logic [7:0] se);
        int mins;
        int secs;
        mins = clampd(int'(mi[7:4]), 9) * 10 + clampd(int'(mi[3:0]), 9);
        secs = clampd(int'(se[7:4]), 5) * 10 + clampd(int'(se[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    function automatic logic [15:0] to_digits(input int s);
        int mins;
        int secs;
        logic [15:0] d;
        mins = s / 60;
        secs = s % 60;
        d[3:0]   = 4'(secs % 10);
        d[7:4]   = 4'(secs / 10);
        d[11:8]  = 4'(mins % 10);
        d[15:12] = 4'((mins / 10) % 10);
        return d;
    endfunction

    // Reference model in whole seconds.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_sec = 0; m_pre = 0; m_presc = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_pre = preset_secs(min_in, sec_in);
                m_sec = m_pre; m_presc = 0; m_mode = M_IDLE;
            end else if (pause && m_mode == M_RUN) begin
                m_mode = M_PAUS;
            end else if (start && m_mode != M_RUN) begin
                if (m_mode == M_IDLE && m_sec != 0) begin
                    m_mode = M_RUN; m_presc = 0;
                end else if (m_mode == M_PAUS) begin
                    m_mode = M_RUN;
                end else if (m_mode == M_EXP && m_pre != 0) begin
                    m_sec = m_pre; m_presc = 0; m_mode = M_RUN;
                end
            end else if (m_mode == M_RUN && ce) begin
                if (m_presc == int'(TD) - 1) begin
                    m_presc = 0;
                    m_sec = m_sec - 1;
                    if (m_sec == 0) begin
                        m_mode = M_EXP; m_done = 1'b1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_digits",  32'(digits),  32'(to_digits(m_sec)));
            check("model_running", 32'(running), 32'(m_mode == M_RUN));
            check("model_expired", 32'(expired), 32'(m_mode == M_EXP));
            check("model_done",    32'(done),    32'(m_done));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] mi, input logic [7:0] se);
        load = 1'b1; min_in = mi; sec_in = se;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        chk_en = 1'b1;
        step(1);
        check("rst_digits",  32'(digits),  32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_expired", 32'(expired), 32'h0);
        check("rst_done",    32'(done),    32'h0);

        // Start with a zero count is ignored
        do_start();
        check("zero_start_running", 32'(running), 32'h0);

        // 00:03 countdown to expiry
        do_load(8'h00, 8'h03);
        check("load3_digits", 32'(digits), 32'h0003);
        do_start();
        check("start_running", 32'(running), 32'h1);
        step(3);  check("t3_digits",  32'(digits), 32'h0003);
        step(1);  check("t4_digits",  32'(digits), 32'h0002);
        step(4);  check("t8_digits",  32'(digits), 32'h0001);
        step(3);  check("t11_done",   32'(done),   32'h0);
        step(1);
        check("t12_digits",  32'(digits),  32'h0000);
        check("t12_done",    32'(done),    32'h1);
        check("t12_expired", 32'(expired), 32'h1);
        check("t12_running", 32'(running), 32'h0);
        step(1);
        check("t13_done",    32'(done),    32'h0);
        check("t13_expired", 32'(expired), 32'h1);

        // Full borrow chain
        do_load(8'h10, 8'h00);
        do_start();
        step(4);
        check("borrow_digits", 32'(digits), 32'h0959);

        // Sanitising of illegal preset digits
        do_load(8'hAB, 8'h7C);
        check("sanitise_digits", 32'(digits), 32'h9959);

        // Pause keeps prescaler phase; ce=0 freezes time
        do_load(8'h00, 8'h05);
        do_start();
        step(6);
        check("pre_pause_digits", 32'(digits), 32'h0004);
        do_pause();
        check("paused_running", 32'(running), 32'h0);
        step(20);
        check("paused_digits", 32'(digits), 32'h0004);
        do_start();
        check("resume_running", 32'(running), 32'h1);
        step(1);  check("resume1_digits", 32'(digits), 32'h0004);
        step(1);  check("resume2_digits", 32'(digits), 32'h0003);
        ce = 1'b0;
        step(10);
        check("ce_frozen_digits",  32'(digits),  32'h0003);
        check("ce_frozen_running", 32'(running), 32'h1);
        ce = 1'b1;

        // Simultaneous load/pause/start in RUN: load wins
        load = 1'b1; pause = 1'b1; start = 1'b1; min_in = 8'h01; sec_in = 8'h23;
        step(1);
        load = 1'b0; pause = 1'b0; start = 1'b0;
        check("prio_digits",  32'(digits),  32'h0123);
        check("prio_running", 32'(running), 32'h0);
        check("prio_expired", 32'(expired), 32'h0);

        // Restart from EXPIRED reloads the preset
        do_load(8'h00, 8'h03);
        do_start();
        step(12);
        check("exp_state", 32'(expired), 32'h1);
        step(3);
        do_start();
        check("restart_digits",  32'(digits),  32'h0003);
        check("restart_running", 32'(running), 32'h1);
        check("restart_expired", 32'(expired), 32'h0);

        // Reset mid-run at 00:01
        step(8);
        check("pre_reset_digits", 32'(digits), 32'h0001);
        step(2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_digits",  32'(digits),  32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        check("async_rst_expired", 32'(expired), 32'h0);
        check("async_rst_done",    32'(done),    32'h0);
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("post_rst_done", 32'(done), 32'h0);
        end
        check("post_rst_digits", 32'(digits), 32'h0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The block SHALL expose parameter TICK_DIV, default 100_000_000, meaning clk cycles per one-second tick (legal range 2 and above).
REQ-002 The block SHALL expose parameter MIN_DIGITS, default 2, meaning number of BCD minute digits (legal range 1..4).
REQ-003 Port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port load, input, 1 bit: capture preset from min_in/sec_in.
REQ-006 Port start, input, 1 bit: single-cycle request to run/resume/restart.
REQ-007 Port pause, input, 1 bit: single-cycle request to pause.
REQ-008 Port ce, input, 1 bit: prescaler enable; while low, time is frozen and state is unchanged.
REQ-009 Port min_in, input, 4*MIN_DIGITS bits: BCD minutes preset, most significant digit in the top nibble.
REQ-010 Port sec_in, input, 8 bits: BCD seconds preset, tens digit in [7:4].
REQ-011 Port digits, output, 4*(MIN_DIGITS+2) bits: current count as {minutes, sec tens, sec units}.
REQ-012 Port running, output, 1 bit: high in state RUN.
REQ-013 Port expired, output, 1 bit: high in state EXPIRED (LED drive).
REQ-014 Port done, output, 1 bit: one-cycle pulse when the count reaches zero.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, PAUSE and EXPIRED.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 only in RUN with ce=1; on an edge where it equals TICK_DIV-1, it SHALL wrap to 0 and the count SHALL decrement once.
REQ-017 The decrement SHALL be BCD with borrow: sec units 0->9 borrows; sec tens 0->5 borrows; each minute digit 0->9 borrows into the next minute digit.
REQ-018 When a decrement yields all-zero digits, the FSM SHALL enter EXPIRED and assert done for exactly that one cycle; the count SHALL never wrap below zero.
REQ-019 Load in any state SHALL copy the sanitised preset into both the preset register and the count, clear the prescaler, and enter IDLE.
REQ-020 Sanitising SHALL replace any digit >9 with 9 and any sec-tens digit >5 with 5.
REQ-021 Start SHALL move IDLE->RUN, clearing the prescaler, when the count is nonzero, and SHALL be ignored in IDLE when the count is zero.
REQ-022 Start SHALL move PAUSE->RUN with the prescaler value retained.
REQ-023 Start SHALL move EXPIRED->RUN, reloading the count from the preset register and clearing the prescaler; it SHALL stay in EXPIRED if the preset is zero.
REQ-024 Pause SHALL move RUN->PAUSE with count and prescaler held; pause SHALL be ignored in all other states.
REQ-025 Simultaneous requests SHALL be prioritised load > pause > start.
REQ-026 The first decrement after start (with ce held at 1) SHALL become visible on digits exactly TICK_DIV edges after the edge sampling start.
REQ-027 All outputs SHALL be registered or decoded directly from registered state; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 Reset SHALL asynchronously set state IDLE, count 0, preset 0 and prescaler 0, and drive digits=0, running=0, expired=0 and done=0; reset asserted mid-run SHALL abort the run with no done pulse.

Structure
REQ-029 Shared package timer_pkg SHALL hold the state encoding, BCD digit width (4), the units/tens moduli (10, 6) and the sanitise function.
REQ-030 Sub-module bcd_down_digit, with parameter MOD, inputs dec_in/load/load_val and outputs q/borrow, SHALL be instantiated MIN_DIGITS+2 times in a borrow chain.

Verification (TICK_DIV=4, MIN_DIGITS=2)
REQ-031 The bench SHALL cover: load 00:03, start -> digits 00:02/00:01/00:00 at +4/+8/+12 edges; done pulses once at +12; expired=1 afterwards.
REQ-032 The bench SHALL cover: load 10:00, start, run 1 tick -> 09:59 (full borrow chain).
REQ-033 The bench SHALL cover: load min=0xAB, sec=0x7C -> digits 99:59.
REQ-034 The bench SHALL cover: run 00:05, pause after 6 edges, wait 20, start -> next decrement lands 2 edges after resume; ce=0 for 10 edges -> count frozen.
REQ-035 The bench SHALL cover: pause+start+load in the same cycle while in RUN -> IDLE holding the new preset; in EXPIRED, start -> count reloads 00:03 and running=1.
REQ-036 The bench SHALL cover: reset asserted mid-run at 00:01 -> all outputs 0 immediately, with no done pulse.
